coastal_sensor_encoder: RTL

Front-end that turns the six raw coastal hazard sensor lines (H, F, T, I, R, D) into the two clean risk flags consumed by the coastal alert state machine: X (any risk, OR of all sensors) and C_Total (total crisis, AND of all sensors). Each line is synchronised, sampled on a prescaled tick and debounced by a per-channel counter, so the state machine never sees a glitch or a metastable value. A one-cycle update strobe marks every change of X or C_Total.

---
 rtl/coastal_sensor_encoder_if.sv | 20 ++
 rtl/coastal_sensor_encoder.sv | 90 +++++++++
 2 files changed

// File: rtl/coastal_sensor_encoder_if.sv
// Sensor-side bundle of the coastal sensor encoder: raw lines and enable in,
// debounced levels and risk flags out.
interface coastal_sensor_encoder_if;
  logic       enable;
  logic [5:0] sens_raw;
  logic [5:0] sens_stable;
  logic       X;
  logic       C_Total;
  logic       upd;

  modport master (
    output enable, sens_raw,
    input  sens_stable, X, C_Total, upd
  );

  modport slave (
    input  enable, sens_raw,
    output sens_stable, X, C_Total, upd
  );
endinterface

// File: rtl/coastal_sensor_encoder.sv
// Synchronises, samples and debounces six hazard lines, then encodes them into
// the any-risk (X) and total-crisis (C_Total) flags with a change strobe.
module coastal_sensor_encoder #(
  parameter int SAMPLE_DIV = 16,
  parameter int DEB_LEN    = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  coastal_sensor_encoder_if.slave   bus
);

  localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CW = $clog2(DEB_LEN) + 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEB_LEN - 1);

  logic [5:0]    sync_meta;
  logic [5:0]    sync;
  logic [PW-1:0] pcnt;
  logic          tick;
  logic [5:0]    s;
  logic [CW-1:0] cnt [6];
  logic          x_q;
  logic          c_q;
  logic          upd_q;

  // Two-flop synchroniser; runs regardless of enable so sync is always fresh.
  // NOTE: every flop here uses non-blocking assignment so all registers see
  // pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= bus.sens_raw;
      sync      <= sync_meta;
    end
  end

  assign tick = bus.enable && (pcnt == PCNT_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt <= '0;
    end else if (!bus.enable || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // NOTE: the per-channel counters are ordinary registers, not a RAM, so they
  // are cleared by reset; a partial run must never survive reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s <= '0;
      for (int i = 0; i < 6; i++) cnt[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < 6; i++) begin
        if (sync[i] == s[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          s[i]   <= sync[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Both flags come from the same s snapshot, so C_Total=1 implies X=1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q   <= 1'b0;
      c_q   <= 1'b0;
      upd_q <= 1'b0;
    end else begin
      x_q   <= |s;
      c_q   <= &s;
      upd_q <= ({|s, &s} != {x_q, c_q});
    end
  end

  assign bus.sens_stable = s;
  assign bus.X           = x_q;
  assign bus.C_Total     = c_q;
  assign bus.upd         = upd_q;

endmodule
